microsequencer: RTL and testbench

MICROSEQUENCER -- requirements
Module: microsequencer

---
 rtl/microsequencer.sv | 156 +++++++++++++++
 tb/tb_microsequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/microsequencer.sv
// Microprogram sequencer: selects the next control-store address from
// increment, direct/dispatch branches and a bounded LIFO return stack.
module microsequencer #(
  parameter int unsigned       AW        = 5,
  parameter int unsigned       CCW       = 4,
  parameter int unsigned       DEPTH     = 4,
  parameter logic [AW-1:0]     RESET_VEC = '0,
  localparam int unsigned      CSW       = (CCW > 1) ? $clog2(CCW) : 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [AW-1:0]  ibin,
  input  logic [AW-1:0]  sbin,
  input  logic [AW-1:0]  dbin,
  input  logic [CCW-1:0] cbin,
  input  logic [2:0]     nssel,
  input  logic [CSW-1:0] ccsel,
  input  logic           ccpol,
  input  logic           stall,
  output logic [AW-1:0]  nextst,
  output logic [AW-1:0]  upc,
  output logic           stk_empty,
  output logic           stk_full,
  output logic           ovf,
  output logic           unf
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned IW  = $clog2(DEPTH);

  typedef enum logic [2:0] {
    NS_SEQ   = 3'd0,
    NS_JMP   = 3'd1,
    NS_IB    = 3'd2,
    NS_SB    = 3'd3,
    NS_CJMP  = 3'd4,
    NS_CALL  = 3'd5,
    NS_RET   = 3'd6,
    NS_CCALL = 3'd7
  } ns_e;

  logic [AW-1:0]  r_upc;
  logic [SPW-1:0] r_sp;
  logic           r_empty;
  logic           r_full;
  logic           r_ovf;
  logic           r_unf;
  logic [AW-1:0]  r_stk [DEPTH];

  logic           w_cond;
  logic [AW-1:0]  w_inc;
  logic [AW-1:0]  w_top;
  logic [SPW-1:0] w_sp_m1;
  logic [AW-1:0]  w_next;
  logic           w_push;
  logic           w_pop;
  logic [AW-1:0]  w_upc_nxt;
  logic [SPW-1:0] w_sp_nxt;
  logic           w_ovf_nxt;
  logic           w_unf_nxt;

  assign w_inc   = r_upc + AW'(1);
  assign w_sp_m1 = r_sp - SPW'(1);
  assign w_top   = r_stk[w_sp_m1[IW-1:0]];

  // Condition select; an index past the last code bit never branches.
  always_comb begin
    w_cond = 1'b0;
    if (32'(ccsel) < CCW) w_cond = ~(cbin[ccsel] ^ ccpol);
  end

  // Next-address mux and stack request decode.
  always_comb begin
    w_next = w_inc;
    w_push = 1'b0;
    w_pop  = 1'b0;
    if (reset) begin
      w_next = RESET_VEC;
    end else if (stall) begin
      w_next = r_upc;
    end else begin
      unique case (ns_e'(nssel))
        NS_SEQ:  w_next = w_inc;
        NS_JMP:  w_next = dbin;
        NS_IB:   w_next = ibin;
        NS_SB:   w_next = sbin;
        NS_CJMP: w_next = w_cond ? dbin : w_inc;
        NS_CALL: begin
          w_next = dbin;
          w_push = 1'b1;
        end
        NS_RET: begin
          w_pop  = 1'b1;
          w_next = r_empty ? RESET_VEC : w_top;
        end
        NS_CCALL: begin
          if (w_cond) begin
            w_next = dbin;
            w_push = 1'b1;
          end
        end
        default: w_next = w_inc;
      endcase
    end
  end

  // Next register state; overflowing pushes and underflowing pops leave sp alone.
  always_comb begin
    w_upc_nxt = r_upc;
    w_sp_nxt  = r_sp;
    w_ovf_nxt = r_ovf;
    w_unf_nxt = r_unf;
    if (!stall) begin
      w_upc_nxt = w_next;
      if (w_push) begin
        if (r_full) w_ovf_nxt = 1'b1;
        else        w_sp_nxt  = r_sp + SPW'(1);
      end
      if (w_pop) begin
        if (r_empty) w_unf_nxt = 1'b1;
        else         w_sp_nxt  = w_sp_m1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_upc   <= RESET_VEC;
      r_sp    <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_upc   <= w_upc_nxt;
      r_sp    <= w_sp_nxt;
      r_empty <= (w_sp_nxt == '0);
      r_full  <= (w_sp_nxt == SPW'(DEPTH));
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  // Stack storage needs no reset; w_push is already cleared under reset/stall.
  always_ff @(posedge clock) begin
    if (w_push && !r_full) r_stk[r_sp[IW-1:0]] <= w_inc;
  end

  assign nextst    = w_next;
  assign upc       = r_upc;
  assign stk_empty = r_empty;
  assign stk_full  = r_full;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

endmodule

// File: tb/tb_microsequencer.sv
// Directed self-checking bench for microsequencer (AW=5, CCW=4, DEPTH=4, RESET_VEC=0).
module tb_microsequencer;

  localparam int unsigned AW  = 5;
  localparam int unsigned CCW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] ibin, sbin, dbin;
  logic [CCW-1:0] cbin;
  logic [2:0]    nssel;
  logic [1:0]    ccsel;
  logic          ccpol, stall;
  logic [AW-1:0] nextst, upc;
  logic          stk_empty, stk_full, ovf, unf;

  int n_cmp = 0;
  int n_err = 0;

  microsequencer #(.AW(5), .CCW(4), .DEPTH(4), .RESET_VEC(5'd0)) dut (
    .clock(clock), .reset(reset), .ibin(ibin), .sbin(sbin), .dbin(dbin),
    .cbin(cbin), .nssel(nssel), .ccsel(ccsel), .ccpol(ccpol), .stall(stall),
    .nextst(nextst), .upc(upc), .stk_empty(stk_empty), .stk_full(stk_full),
    .ovf(ovf), .unf(unf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_status(input string tag, input logic e, input logic f,
                            input logic o, input logic u);
    chk({tag, "_empty"}, 32'(stk_empty), 32'(e));
    chk({tag, "_full"},  32'(stk_full),  32'(f));
    chk({tag, "_ovf"},   32'(ovf),       32'(o));
    chk({tag, "_unf"},   32'(unf),       32'(u));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; stall = 1'b0; nssel = 3'd1; dbin = 5'd7;
    settle();
    chk({tag, "_nextst_in_reset"}, 32'(nextst), 32'd0);
    tick();
    reset = 1'b0; nssel = 3'd0;
    settle();
    chk({tag, "_upc"}, 32'(upc), 32'd0);
    chk_status(tag, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic jump_to(input logic [AW-1:0] a);
    nssel = 3'd1; dbin = a;
    tick();
  endtask

  logic [AW-1:0] call_tgt [5];
  logic [AW-1:0] ret_exp  [4];

  initial begin
    reset = 1'b1; ibin = '0; sbin = '0; dbin = '0; cbin = '0;
    nssel = '0; ccsel = '0; ccpol = 1'b0; stall = 1'b0;
    call_tgt = '{5'd8, 5'd16, 5'd20, 5'd24, 5'd28};
    ret_exp  = '{5'd1, 5'd9, 5'd17, 5'd21};

    // Reset state and SEQ wrap over 33 cycles
    do_reset("rst0");
    nssel = 3'd0;
    for (int i = 0; i < 33; i++) begin
      settle();
      chk($sformatf("seq_upc_%0d", i), 32'(upc), 32'(i % 32));
      chk($sformatf("seq_next_%0d", i), 32'(nextst), 32'((i + 1) % 32));
      @(posedge clock);
      #0;
    end
    #1;

    // Conditional jump, dispatch modes
    do_reset("rst1");
    jump_to(5'd3);
    chk("jmp_upc3", 32'(upc), 32'd3);
    nssel = 3'd4; cbin = 4'b0100; ccsel = 2'd2; dbin = 5'd9; ccpol = 1'b1;
    settle();
    chk("cjmp_taken", 32'(nextst), 32'd9);
    ccpol = 1'b0;
    settle();
    chk("cjmp_not_taken", 32'(nextst), 32'd4);
    ccsel = 2'd1; ccpol = 1'b1;
    settle();
    chk("cjmp_bit1_clear", 32'(nextst), 32'd4);
    nssel = 3'd2; ibin = 5'd17;
    settle();
    chk("ib_next", 32'(nextst), 32'd17);
    nssel = 3'd3; sbin = 5'd22;
    settle();
    chk("sb_next", 32'(nextst), 32'd22);
    nssel = 3'd7; ccsel = 2'd2; ccpol = 1'b0; dbin = 5'd12;
    settle();
    chk("ccall_not_taken", 32'(nextst), 32'd4);
    tick();
    chk("ccall_nt_empty", 32'(stk_empty), 32'd1);
    ccpol = 1'b1;
    settle();
    chk("ccall_taken", 32'(nextst), 32'd12);
    tick();
    chk("ccall_upc", 32'(upc), 32'd12);
    chk("ccall_pushed", 32'(stk_empty), 32'd0);
    nssel = 3'd6;
    settle();
    chk("ccall_ret", 32'(nextst), 32'd5);

    // CALL / RET pair
    do_reset("rst2");
    jump_to(5'd2);
    nssel = 3'd5; dbin = 5'd10;
    settle();
    chk("call_next", 32'(nextst), 32'd10);
    tick();
    chk("call_upc", 32'(upc), 32'd10);
    chk("call_not_empty", 32'(stk_empty), 32'd0);
    nssel = 3'd6;
    settle();
    chk("ret_next", 32'(nextst), 32'd3);
    tick();
    chk("ret_upc", 32'(upc), 32'd3);
    chk("ret_empty", 32'(stk_empty), 32'd1);

    // Overflow and underflow at DEPTH=4
    do_reset("rst3");
    nssel = 3'd5;
    for (int i = 0; i < 5; i++) begin
      dbin = call_tgt[i];
      settle();
      chk($sformatf("deep_call_next_%0d", i), 32'(nextst), 32'(call_tgt[i]));
      tick();
      chk($sformatf("deep_call_upc_%0d", i), 32'(upc), 32'(call_tgt[i]));
      chk($sformatf("deep_call_full_%0d", i), 32'(stk_full), 32'(i >= 3));
      chk($sformatf("deep_call_ovf_%0d", i), 32'(ovf), 32'(i == 4));
    end
    nssel = 3'd6;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("deep_ret_next_%0d", i), 32'(nextst), 32'(ret_exp[3 - i]));
      tick();
      chk($sformatf("deep_ret_upc_%0d", i), 32'(upc), 32'(ret_exp[3 - i]));
    end
    chk_status("after4ret", 1'b1, 1'b0, 1'b1, 1'b0);
    settle();
    chk("underflow_next", 32'(nextst), 32'd0);
    tick();
    chk("underflow_upc", 32'(upc), 32'd0);
    chk_status("after5ret", 1'b1, 1'b0, 1'b1, 1'b1);

    // Stall holds a pending CALL
    do_reset("rst4");
    jump_to(5'd5);
    nssel = 3'd5; dbin = 5'd12; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("stall_next_%0d", i), 32'(nextst), 32'd5);
      tick();
      chk($sformatf("stall_upc_%0d", i), 32'(upc), 32'd5);
      chk($sformatf("stall_empty_%0d", i), 32'(stk_empty), 32'd1);
    end
    stall = 1'b0;
    settle();
    chk("unstall_next", 32'(nextst), 32'd12);
    tick();
    chk("unstall_upc", 32'(upc), 32'd12);
    chk("unstall_pushed", 32'(stk_empty), 32'd0);

    // Reset with two entries on the stack, overriding stall and a CALL
    dbin = 5'd15;
    tick();
    chk("second_call_upc", 32'(upc), 32'd15);
    reset = 1'b1; stall = 1'b1; nssel = 3'd5; dbin = 5'd20;
    settle();
    chk("rst_pri_next", 32'(nextst), 32'd0);
    tick();
    reset = 1'b0; stall = 1'b0; nssel = 3'd6;
    settle();
    chk("rst_pri_upc", 32'(upc), 32'd0);
    chk_status("rst_pri", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_ret_next", 32'(nextst), 32'd0);
    tick();
    chk("post_rst_ret_unf", 32'(unf), 32'd1);
    chk("post_rst_ret_empty", 32'(stk_empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
